// File: rtl/thermal_plant_pkg.sv
// Shared widths and operating-mode encodings for the thermal plant model.
// The mode values match the raw {heating, cooling} command bits.
package thermal_plant_pkg;

   localparam int TEMP_W = 5;
   localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

   typedef enum logic [1:0] {
      MODE_DRIFT = 2'b00,
      MODE_COOL  = 2'b01,
      MODE_HEAT  = 2'b10,
      MODE_FAULT = 2'b11
   } mode_t;

endpackage

// File: rtl/thermal_plant_rate_divider.sv
// Restartable modulo-div counter; tick is high on the edge where the count wraps.
// A restart or a disabled cycle forces the count back to zero without a tick.
module rate_divider #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             enable,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   logic [CNT_W-1:0] count;

   assign tick = enable && !restart && (count == div - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst || restart || !enable || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/thermal_plant.sv
// Behavioural thermal plant: temperature ramps under heater/cooler commands and
// drifts toward ambient when idle; conflicting commands freeze it and latch fault.
module thermal_plant
   import thermal_plant_pkg::*;
#(
   parameter int RATE_DIV   = 4,
   parameter int DRIFT_DIV  = 8,
   parameter int RESET_TEMP = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              heating,
   input  logic              cooling,
   input  logic [TEMP_W-1:0] ambient,
   output logic [TEMP_W-1:0] temperature,
   output logic              temp_changed,
   output logic              fault
);

   localparam logic [7:0]        RATE_DIV_C   = 8'(RATE_DIV);
   localparam logic [7:0]        DRIFT_DIV_C  = 8'(DRIFT_DIV);
   localparam logic [TEMP_W-1:0] RESET_TEMP_C = TEMP_W'(RESET_TEMP);

   function automatic logic [TEMP_W-1:0] sat_inc(input logic [TEMP_W-1:0] t);
      return (t == TEMP_MAX) ? t : t + TEMP_W'(1);
   endfunction

   function automatic logic [TEMP_W-1:0] sat_dec(input logic [TEMP_W-1:0] t);
      return (t == '0) ? t : t - TEMP_W'(1);
   endfunction

   function automatic logic [TEMP_W-1:0] drift_toward(input logic [TEMP_W-1:0] t,
                                                      input logic [TEMP_W-1:0] a);
      if (t < a)      return t + TEMP_W'(1);
      else if (t > a) return t - TEMP_W'(1);
      else            return t;
   endfunction

   mode_t             mode_d;
   mode_t             mode_q;
   logic [7:0]        div_sel;
   logic              step;
   logic [TEMP_W-1:0] temp_next;

   always_comb begin
      mode_d = MODE_DRIFT;
      case ({heating, cooling})
         2'b10:   mode_d = MODE_HEAT;
         2'b01:   mode_d = MODE_COOL;
         2'b11:   mode_d = MODE_FAULT;
         default: mode_d = MODE_DRIFT;
      endcase
      div_sel = (mode_d == MODE_DRIFT) ? DRIFT_DIV_C : RATE_DIV_C;
   end

   // A mode change restarts the step phase; FAULT keeps the counter parked at zero.
   rate_divider #(.CNT_W(8)) u_div (
      .clk     (clk),
      .rst     (rst),
      .restart (mode_d != mode_q),
      .enable  (mode_d != MODE_FAULT),
      .div     (div_sel),
      .tick    (step)
   );

   always_comb begin
      temp_next = temperature;
      if (step) begin
         case (mode_q)
            MODE_HEAT:  temp_next = sat_inc(temperature);
            MODE_COOL:  temp_next = sat_dec(temperature);
            MODE_DRIFT: temp_next = drift_toward(temperature, ambient);
            default:    temp_next = temperature;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_DRIFT;
         temperature  <= RESET_TEMP_C;
         temp_changed <= 1'b0;
         fault        <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         temperature  <= temp_next;
         temp_changed <= (temp_next != temperature);
         if (mode_d == MODE_FAULT) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_thermal_plant.sv
// Self-checking bench for thermal_plant: directed scenarios with literal
// expectations plus randomized commands checked every cycle against a model.
module tb_thermal_plant;

   logic       clk;
   logic       rst;
   logic       heating;
   logic       cooling;
   logic [4:0] ambient;
   logic [4:0] temperature;
   logic       temp_changed;
   logic       fault;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;

   thermal_plant #(.RATE_DIV(4), .DRIFT_DIV(8), .RESET_TEMP(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .heating      (heating),
      .cooling      (cooling),
      .ambient      (ambient),
      .temperature  (temperature),
      .temp_changed (temp_changed),
      .fault        (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Reference model: time since the command last changed decides when steps land.
   int  m_temp, m_elapsed, m_prev;
   bit  m_fault, m_chg, m_valid;

   function automatic int div_of(input int mode);
      return (mode == 0) ? 8 : 4;
   endfunction

   always @(posedge clk) begin
      int mode, old;
      if (rst) begin
         m_temp    = 20;
         m_elapsed = 0;
         m_prev    = 0;
         m_fault   = 0;
         m_chg     = 0;
         m_valid   = 1;
      end else if (m_valid) begin
         mode = {30'd0, heating, cooling};
         old  = m_temp;
         if (mode != m_prev) m_elapsed = 0;
         else                m_elapsed++;
         if (mode == m_prev && mode != 3 && m_elapsed > 0 && (m_elapsed % div_of(mode)) == 0) begin
            case (mode)
               2: if (m_temp < 31) m_temp++;
               1: if (m_temp > 0)  m_temp--;
               0: begin
                  if (m_temp < int'(ambient))      m_temp++;
                  else if (m_temp > int'(ambient)) m_temp--;
               end
               default: ;
            endcase
         end
         if (mode == 3) m_fault = 1;
         m_prev = mode;
         m_chg  = (m_temp != old);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_temperature", int'(temperature), m_temp);
         chk("model_temp_changed", int'(temp_changed), int'(m_chg));
         chk("model_fault", int'(fault), int'(m_fault));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         pulses += int'(temp_changed);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("reset_temperature", int'(temperature), 20);
      chk("reset_temp_changed", int'(temp_changed), 0);
      chk("reset_fault", int'(fault), 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; heating = 1'b0; cooling = 1'b0; ambient = 5'd20;
      @(negedge clk);

      // Heating ramp and saturation at the top
      do_reset();
      heating = 1'b1; pulses = 0;
      tick(4);  chk("heat_before_first_step", int'(temperature), 20);
      tick(1);  chk("heat_first_step", int'(temperature), 21);
      tick(36); chk("heat_40_cycles", int'(temperature), 30);
      chk("heat_40_pulses", pulses, 10);
      tick(4);  chk("heat_saturate_31", int'(temperature), 31);
      pulses = 0;
      tick(16); chk("heat_hold_31", int'(temperature), 31);
      chk("heat_no_pulses_saturated", pulses, 0);

      // Cooling ramp and saturation at zero
      heating = 1'b0;
      do_reset();
      cooling = 1'b1;
      tick(81); chk("cool_reach_0", int'(temperature), 0);
      tick(10); chk("cool_hold_0", int'(temperature), 0);

      // Idle drift toward ambient, then ambient moved mid-drift
      cooling = 1'b0; ambient = 5'd16;
      do_reset();
      tick(7);  chk("drift_before_step", int'(temperature), 20);
      tick(1);  chk("drift_first_step", int'(temperature), 19);
      tick(24); chk("drift_reach_ambient", int'(temperature), 16);
      tick(8);  chk("drift_stable", int'(temperature), 16);
      ambient = 5'd18;
      tick(8);  chk("drift_new_ambient", int'(temperature), 17);

      // Conflicting commands latch fault and freeze temperature
      ambient = 5'd20;
      do_reset();
      heating = 1'b1; cooling = 1'b1;
      tick(1);  chk("fault_first_edge", int'(fault), 1);
      tick(2);  chk("fault_temp_frozen", int'(temperature), 20);
      cooling = 1'b0;
      tick(4);  chk("fault_resume_wait", int'(temperature), 20);
      tick(1);  chk("fault_resume_step", int'(temperature), 21);
      chk("fault_sticky_heating", int'(fault), 1);
      heating = 1'b0;
      tick(5);  chk("fault_sticky_idle", int'(fault), 1);

      // Reset mid-count at 27 while heating
      do_reset();
      heating = 1'b1;
      tick(29); chk("pre_reset_27", int'(temperature), 27);
      tick(2);
      do_reset();
      tick(4);  chk("post_reset_wait", int'(temperature), 20);
      tick(1);  chk("post_reset_step", int'(temperature), 21);

      // Randomized command segments
      for (int seg = 0; seg < 300; seg++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r == 0)      {heating, cooling} = 2'b11;
         else if (r < 7)  {heating, cooling} = 2'b10;
         else if (r < 13) {heating, cooling} = 2'b01;
         else             {heating, cooling} = 2'b00;
         if ($urandom_range(0, 3) == 0) ambient = 5'($urandom_range(0, 31));
         rst = ($urandom_range(0, 49) == 0);
         tick(1);
         rst = 1'b0;
         tick(int'($urandom_range(0, 24)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/thermal_plant.md
THERMAL_PLANT -- requirements
Module: thermal_plant

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide RATE_DIV, 4, clock cycles per 1-degree step while heating or cooling (legal range 2..255).
REQ-002 SHALL provide DRIFT_DIV, 8, clock cycles per 1-degree step toward ambient while idle (legal range 2..255).
REQ-003 SHALL provide RESET_TEMP, 20, temperature value loaded on reset (0..31).

Ports (name, direction, width, meaning):
REQ-004 SHALL provide clk, input, 1, single system clock; all state updates on rising edge.
REQ-005 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide heating, input, 1, heater command from the climate controller.
REQ-007 SHALL provide cooling, input, 1, cooler command from the climate controller.
REQ-008 SHALL provide ambient, input, 5, unsigned ambient temperature target for idle drift.
REQ-009 SHALL provide temperature, output, 5, unsigned modelled temperature, registered.
REQ-010 SHALL provide temp_changed, output, 1, one-cycle pulse on the edge at which temperature changes value.
REQ-011 SHALL provide fault, output, 1, sticky flag indicating that heating and cooling were both asserted.

Function
REQ-012 SHALL decode {heating,cooling} each cycle: 10=HEAT, 01=COOL, 00=DRIFT, 11=FAULT.
REQ-013 SHALL register the decoded mode as mode_q each edge; when the decoded mode differs from mode_q, the step counter SHALL clear to 0 with no step on that edge.
REQ-014 SHALL otherwise increment the step counter each edge; when the counter equals DIV-1 (RATE_DIV for HEAT/COOL, DRIFT_DIV for DRIFT), it SHALL wrap to 0 and issue one step on that edge.
REQ-015 Latency: with a mode first sampled at edge N and held, the first step SHALL take effect at edge N+DIV, then every DIV edges.
REQ-016 HEAT step: temperature+1, saturating at 31; COOL step: temperature-1, saturating at 0; no wrap-around under any condition.
REQ-017 DRIFT step: temperature moves 1 toward ambient; if equal, temperature holds.
REQ-018 A step that produces no value change (saturation, or temperature equal to ambient) SHALL not pulse temp_changed; the counter SHALL keep wrapping.
REQ-019 FAULT: temperature SHALL freeze, the counter SHALL hold at 0, and fault SHALL set on the same edge and remain set after both inputs drop, until rst.
REQ-020 A change of ambient mid-DRIFT SHALL not restart the counter; the next step SHALL use the new ambient value.
REQ-021 temp_changed SHALL be high only on the cycle following the edge at which temperature was updated.

Reset
REQ-022 On any edge with rst=1: temperature=RESET_TEMP, counter=0, mode_q=DRIFT, fault=0, temp_changed=0; rst SHALL take priority over all other inputs, including mid-count and FAULT.
REQ-023 On the first edge after rst deasserts, mode comparison SHALL proceed per REQ-013, against mode_q=DRIFT.

Structure
REQ-024 A shared package SHALL hold TEMP_W=5, TEMP_MAX=31, and the 2-bit mode encodings MODE_DRIFT/MODE_HEAT/MODE_COOL/MODE_FAULT.
REQ-025 One sub-module, rate_divider (restartable modulo counter emitting a terminal tick, with the divide value as an input), SHALL implement the step counter; saturation and drift logic SHALL stay in thermal_plant.

Verification (RATE_DIV=4, DRIFT_DIV=8, RESET_TEMP=20)
REQ-026 Reset, then heating=1 for 40 cycles -> temperature 21 at edge 4 after the mode is sampled, 30 after 40 cycles, 10 temp_changed pulses.
REQ-027 heating=1 held 60 cycles from 20 -> temperature reaches 31 at cycle 44 and holds; no temp_changed pulses after that.
REQ-028 cooling=1 from 20 for 90 cycles -> reaches 0 at cycle 80 and holds at 0; no underflow to 31.
REQ-029 Both low, ambient=16, temperature=20 -> 19 at cycle 8, 16 at cycle 32, then stable; ambient changed to 18 -> 17 after 8 more cycles.
REQ-030 heating=cooling=1 for 3 cycles, then heating only -> fault=1 from the first edge, temperature frozen during fault, fault remains 1 until rst, heating resumes per REQ-015.
REQ-031 rst pulsed for 1 cycle when temperature=27 mid-count -> temperature=20, temp_changed=0, fault=0 on that edge; next step occurs DIV edges after release.
